// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_pkg                                                    |
// | Description : Shared types and constants for the burst memory responder. |
// |               FSM state encoding, burst geometry, data-bus direction     |
// |               codes and the address bit positions of offset and block.   |
// | Ports       : none (package)                                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATENCY = 3'd1,
    DRIVE   = 3'd2,
    STROBE  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int   BURST_LENGTH   = 8;
  localparam int   BEAT_W         = 3;

  // Encoding of we_MEM: the bus is active-low write.
  localparam logic DATA_BUS_READ  = 1'b1;
  localparam logic DATA_BUS_WRITE = 1'b0;

  // Byte address layout: [2:0] byte lane (ignored), [5:3] word offset
  // inside the 8-word block, [ADDR_WIDTH-1:6] block index.
  localparam int   OFFSET_LSB     = 3;
  localparam int   OFFSET_MSB     = 5;
  localparam int   BLOCK_LSB      = 6;

endpackage
`default_nettype wire

// File: rtl/mem_burst_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_burst_responder_if                                     |
// | Description : Request/handshake bundle between the L2 side (master) and  |
// |               the burst responder (slave).                               |
// | Signals     : req_MEM  request valid         (master -> slave)           |
// |               we_MEM   active-low write      (master -> slave)           |
// |               addr_MEM byte address          (master -> slave)           |
// |               stb      beat strobe (toggle)  (slave  -> master)          |
// |               busy     burst in progress     (slave  -> master)          |
// |               The bidirectional data bus is a plain inout of the top.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface mem_burst_responder_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  req_MEM;
  logic                  we_MEM;
  logic [ADDR_WIDTH-1:0] addr_MEM;
  logic                  stb;
  logic                  busy;

  modport master (
    output req_MEM,
    output we_MEM,
    output addr_MEM,
    input  stb,
    input  busy
  );

  modport slave (
    input  req_MEM,
    input  we_MEM,
    input  addr_MEM,
    output stb,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/mem_burst_responder_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_array                                                  |
// | Description : DEPTH x DATA_WIDTH storage, synchronous write and          |
// |               combinational read. Not reset: contents survive reset.     |
// | Ports       : clk      clock                                             |
// |               we_i     write enable                                      |
// |               waddr_i  write index                                       |
// |               wdata_i  write data                                        |
// |               raddr_i  read index                                        |
// |               rdata_o  read data (combinational)                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_array #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire logic                  clk,
  input  wire logic                  we_i,
  input  wire logic [IDX_W-1:0]      waddr_i,
  input  wire logic [DATA_WIDTH-1:0] wdata_i,
  input  wire logic [IDX_W-1:0]      raddr_i,
  output logic      [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/mem_burst_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_burst_responder                                        |
// | Description : Memory model answering 8-beat wrapping bursts from L2.     |
// |               After ACCESS_LATENCY cycles each beat takes a DRIVE and a  |
// |               STROBE cycle; every stb toggle marks one beat.             |
// | Ports       : clk       clock                                            |
// |               reset_n   synchronous active-low reset                     |
// |               bus       slave modport: req_MEM, we_MEM, addr_MEM,        |
// |                         stb, busy                                        |
// |               data_MEM  bidirectional burst data bus                     |
// | Config      : MEM_CRITICAL_WORD_FIRST_EN - when defined beat 0 is the    |
// |               requested word offset; otherwise beat 0 is offset 0.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_burst_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH_L2  = 64,
  parameter int DEPTH_WORDS    = 1024,
  parameter int ACCESS_LATENCY = 4
) (
  input  wire logic                     clk,
  input  wire logic                     reset_n,
  mem_burst_responder_if.slave          bus,
  inout  wire logic [DATA_WIDTH_L2-1:0] data_MEM
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int LAT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(ACCESS_LATENCY - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LENGTH - 1);

  state_e                            state_q;
  logic [BEAT_W-1:0]                 beat_q;
  logic [BEAT_W-1:0]                 beat_d;
  logic [LAT_W-1:0]                  lat_q;
  logic                              stb_q;
  logic                              busy_q;
  logic                              oe_q;
  logic                              we_q;
  logic [DATA_WIDTH_L2-1:0]          data_q;
  logic [ADDR_WIDTH-BLOCK_LSB-1:0]   blk_q;
  logic [BEAT_W-1:0]                 off_q;   // offset of beat 0

  logic                              enter_drive;
  logic [BEAT_W-1:0]                 rd_off;
  logic [BEAT_W-1:0]                 wr_off;
  logic [ADDR_WIDTH-OFFSET_LSB-1:0]  rd_word;
  logic [ADDR_WIDTH-OFFSET_LSB-1:0]  wr_word;
  logic [DATA_WIDTH_L2-1:0]          rd_data;
  logic                              mem_we;
  logic                              unused_bits;

  // A beat starts either at the end of the latency window or after a
  // non-final STROBE; beat_d is the beat being entered at that edge.
  assign enter_drive = ((state_q == LATENCY) && (lat_q == LAT_LAST)) ||
                       ((state_q == STROBE)  && (beat_q != BEAT_LAST));
  assign beat_d      = (state_q == LATENCY) ? '0 : beat_q + BEAT_W'(1);

  // 3-bit adds wrap the offset inside the 8-word block; truncating the
  // word address to IDX_W bits makes upper address bits alias.
  assign rd_off  = off_q + beat_d;
  assign wr_off  = off_q + beat_q;
  assign rd_word = {blk_q, rd_off};
  assign wr_word = {blk_q, wr_off};

  // Capture happens on the edge leaving STROBE; gating with reset_n keeps
  // the beat in flight from being written when a reset aborts the burst.
  assign mem_we = reset_n && (state_q == STROBE) && (we_q == DATA_BUS_WRITE);

  assign unused_bits = ^{bus.addr_MEM[OFFSET_MSB:0], rd_word, wr_word};

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH_L2),
    .DEPTH      (DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_mem_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_word[IDX_W-1:0]),
    .wdata_i (data_MEM),
    .raddr_i (rd_word[IDX_W-1:0]),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= DATA_BUS_READ;
      data_q  <= '0;
      blk_q   <= '0;
      off_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_MEM) begin
            we_q    <= bus.we_MEM;
            blk_q   <= bus.addr_MEM[ADDR_WIDTH-1:BLOCK_LSB];
`ifdef MEM_CRITICAL_WORD_FIRST_EN
            off_q   <= bus.addr_MEM[OFFSET_MSB:OFFSET_LSB];
`else
            off_q   <= '0;
`endif
            lat_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= LATENCY;
          end
        end
        LATENCY: begin
          if (lat_q != LAT_LAST) begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        DRIVE: begin
          state_q <= STROBE;
          // Read data has been on the bus for the whole DRIVE cycle.
          if (we_q == DATA_BUS_READ) begin
            stb_q <= ~stb_q;
          end
        end
        STROBE: begin
          if (beat_q == BEAT_LAST) begin
            state_q <= DONE;
            oe_q    <= 1'b0;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (enter_drive) begin
        beat_q  <= beat_d;
        state_q <= DRIVE;
        if (we_q == DATA_BUS_READ) begin
          oe_q   <= 1'b1;
          data_q <= rd_data;
        end else begin
          // Write: toggle requests the next beat from L2.
          stb_q  <= ~stb_q;
        end
      end
    end
  end

  assign bus.stb  = stb_q;
  assign bus.busy = busy_q;
  assign data_MEM = oe_q ? data_q : {DATA_WIDTH_L2{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_burst_responder                                     |
// | Description : Directed, table-driven bench for mem_burst_responder.      |
// |               Burst table of writes/reads with hand-computed words, plus |
// |               sequences for request during latency, reset mid-read and   |
// |               reset mid-write. Expectations follow                       |
// |               MEM_CRITICAL_WORD_FIRST_EN when it is defined.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mem_burst_responder;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 1024;
  localparam int LAT   = 4;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
  localparam int CWF   = 1;
`else
  localparam int CWF   = 0;
`endif

  localparam logic [63:0] PAT_A = 64'h1111_0000_0000_0000;
  localparam logic [63:0] PAT_B = 64'h2222_0000_0000_0000;
  localparam logic [63:0] PAT_C = 64'h3333_0000_0000_0000;
  localparam logic [63:0] PAT_D = 64'h4444_0000_0000_0000;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [63:0] base;  // beat k carries base + ((rot + k) mod 8)
    int          rot;
  } vec_t;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] tb_data;
  logic          tb_oe;
  wire  [DW-1:0] data_bus;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  vec_t vecs[7];
  logic m_p;
  int   m_tg;
  int   m_n;

  mem_burst_responder_if #(.ADDR_WIDTH(AW)) bus ();

  assign data_bus = tb_oe ? tb_data : {DW{1'bz}};

  mem_burst_responder #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH_L2  (DW),
    .DEPTH_WORDS    (DEPTH),
    .ACCESS_LATENCY (LAT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .data_MEM (data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
  endtask

  task automatic check_released(input string name);
    logic [DW-1:0] zv;
    zv = {DW{1'bz}};
    chk_cnt++;
    if ((data_bus === zv) || (data_bus === '0)) pass_cnt++;
    else $display("FAIL %s: data_MEM 0x%h, want high-Z", name, data_bus);
  endtask

  function automatic logic [63:0] exp_word(input logic [63:0] base, input int rot, input int k);
    return base + 64'((rot + k) % 8);
  endfunction

  // Read burst; beats below split expect base, the rest expect base_hi.
  task automatic run_read(input logic [31:0] a, input logic [63:0] base, input int rot,
                          input bit pulse, input int split, input logic [63:0] base_hi);
    int            cycles;
    int            toggles;
    logic          stb0;
    logic          prev_stb;
    logic [DW-1:0] prev_data;
    logic [63:0]   want;
    stb0 = bus.stb;
    bus.req_MEM  = 1'b1;
    bus.we_MEM   = 1'b1;
    bus.addr_MEM = a;
    tick();
    bus.req_MEM = 1'b0;
    check("rd_busy_accept", 64'(bus.busy), 64'd1);
    cycles    = 0;
    toggles   = 0;
    prev_stb  = bus.stb;
    prev_data = data_bus;
    while (bus.busy && cycles < 100) begin
      bus.req_MEM = (pulse && cycles == 1);
      tick();
      cycles++;
      if (bus.stb != prev_stb) begin
        if (toggles < 8) begin
          want = (toggles < split) ? exp_word(base, rot, toggles) : exp_word(base_hi, rot, toggles);
          check($sformatf("rd_beat%0d_drive", toggles), prev_data, want);
          check($sformatf("rd_beat%0d_strobe", toggles), data_bus, want);
        end
        toggles++;
      end
      prev_stb  = bus.stb;
      prev_data = data_bus;
    end
    bus.req_MEM = 1'b0;
    check("rd_busy_cycles", 64'(cycles), 64'(LAT + 17));
    check("rd_stb_toggles", 64'(toggles), 64'd8);
    check("rd_stb_level", 64'(bus.stb), 64'(stb0));
    check_released("rd_bus_released");
    if (pulse) begin
      repeat (3) tick();
      check("rd_no_second_burst", 64'(bus.busy), 64'd0);
    end
  endtask

  // Write burst; beat k drives base + k. abort_beat < 8 resets the DUT
  // during the DRIVE cycle of that beat.
  task automatic run_write(input logic [31:0] a, input logic [63:0] base, input int abort_beat);
    logic p;
    bit   seen;
    int   n;
    bus.req_MEM  = 1'b1;
    bus.we_MEM   = 1'b0;
    bus.addr_MEM = a;
    tick();
    bus.req_MEM = 1'b0;
    bus.we_MEM  = 1'b1;
    p = bus.stb;
    for (int k = 0; k < 8; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        tick();
        if (bus.stb != p) begin
          seen = 1'b1;
          p    = bus.stb;
        end
      end
      check($sformatf("wr_stb_beat%0d", k), 64'(seen), 64'd1);
      if (!seen) break;
      tb_data = base + 64'(k);
      tb_oe   = 1'b1;
      if (k == abort_beat) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tb_oe   = 1'b0;
        check("wr_abort_busy", 64'(bus.busy), 64'd0);
        check("wr_abort_stb", 64'(bus.stb), 64'd0);
        return;
      end
    end
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    check("wr_busy_end", 64'(bus.busy), 64'd0);
    tb_oe = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.req_MEM  = 1'b0;
    bus.we_MEM   = 1'b1;
    bus.addr_MEM = '0;
    tb_oe        = 1'b0;
    tb_data      = '0;

    vecs[0] = '{1'b1, 32'h0000_0040, PAT_A, 0};
    vecs[1] = '{1'b0, 32'h0000_0040, PAT_A, 0};
    vecs[2] = '{1'b0, 32'h0000_0048, PAT_A, CWF};
    vecs[3] = '{1'b0, 32'h0000_2040, PAT_A, 0};
    vecs[4] = '{1'b1, 32'h0000_0098, PAT_B, 0};
    vecs[5] = '{1'b0, 32'h0000_0080, PAT_B, (CWF != 0) ? 5 : 0};
    vecs[6] = '{1'b0, 32'h0000_009F, PAT_B, 0};

    repeat (3) tick();
    check("reset_stb", 64'(bus.stb), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check_released("reset_bus_released");
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_write) run_write(vecs[i].addr, vecs[i].base, 8);
      else run_read(vecs[i].addr, vecs[i].base, vecs[i].rot, 1'b0, 8, vecs[i].base);
      repeat (2) tick();
    end

    // Request pulsed during LATENCY must be ignored.
    run_read(32'h0000_0040, PAT_A, 0, 1'b1, 8, PAT_A);
    repeat (2) tick();

    // Reset during read beat 3, then a clean read of the same block.
    bus.req_MEM  = 1'b1;
    bus.we_MEM   = 1'b1;
    bus.addr_MEM = 32'h0000_0040;
    tick();
    bus.req_MEM = 1'b0;
    m_p  = bus.stb;
    m_tg = 0;
    m_n  = 0;
    while (m_tg < 3 && m_n < 60) begin
      tick();
      m_n++;
      if (bus.stb != m_p) begin
        m_tg++;
        m_p = bus.stb;
      end
    end
    check("rst_rd_reached_beat3", 64'(m_tg), 64'd3);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_rd_stb", 64'(bus.stb), 64'd0);
    check("rst_rd_busy", 64'(bus.busy), 64'd0);
    check_released("rst_rd_bus_released");
    tick();
    run_read(32'h0000_0040, PAT_A, 0, 1'b0, 8, PAT_A);
    repeat (2) tick();

    // Write aborted by reset at beat 4 keeps only beats 0..3.
    run_write(32'h0000_00C0, PAT_C, 8);
    repeat (2) tick();
    run_write(32'h0000_00C0, PAT_D, 4);
    repeat (2) tick();
    run_read(32'h0000_00C0, PAT_D, 0, 1'b0, 4, PAT_C);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
